triumph_mem_arbiter: RTL and testbench

Shares one single-port, pipelined, fixed-latency memory between the core's instruction-fetch port and its load/store port. This lets the core run from a unified RAM instead of separate instruction and data memories. It sits between the core and the memory macro and arbitrates one access per cycle. Read data is routed back to the requester that issued it, and a stall is reported while any request waits.

---
 rtl/triumph_pkg.sv | 24 ++
 rtl/triumph_resp_pipe.sv | 32 +++
 rtl/triumph_mem_arbiter.sv | 116 +++++++++++
 tb/tb_triumph_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triumph_pkg.sv
// Shared types for the unified-memory arbiter: response owner encoding,
// the {valid, owner} response tag and the starvation counter width.
package triumph_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } resp_tag_t;

    function automatic resp_tag_t make_tag(input logic valid, input owner_e owner);
        resp_tag_t t;
        t.valid = valid;
        t.owner = owner;
        return t;
    endfunction

endpackage

// File: rtl/triumph_resp_pipe.sv
// Fixed-depth shift register carrying one response tag per cycle so read data
// returning from memory can be steered to the requester that issued it.
module triumph_resp_pipe
    import triumph_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      clr_i,
    input  resp_tag_t tag_i,
    output resp_tag_t tag_o
);

    resp_tag_t stage_q [DEPTH];

    // Shifts every cycle; non-read cycles carry valid = 0 so latency stays fixed.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/triumph_mem_arbiter.sv
// Arbitrates a single-port pipelined memory between instruction fetch and
// load/store, with a bounded-starvation rule for fetch and in-order read return.
module triumph_mem_arbiter
    import triumph_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              stall_o
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starved_c;
    logic             ls_win_c;
    logic             rd_issue_c;
    resp_tag_t        push_tag;
    resp_tag_t        pipe_tag;

    // Arbitration sees only the registered counter and the live requests.
    always_comb begin
        starved_c = 1'b0;
        ls_win_c  = 1'b0;
        if_gnt_o  = 1'b0;
        ls_gnt_o  = 1'b0;
        starved_c = (starve_q >= STARVE_LIM);
        ls_win_c  = ls_req_i & ~(if_req_i & starved_c);
        ls_gnt_o  = ls_win_c & ~rst_i;
        if_gnt_o  = if_req_i & ~ls_win_c & ~rst_i;
    end

    assign stall_o = (if_req_i & ~if_gnt_o) | (ls_req_i & ~ls_gnt_o);

    // Counts load/store grants that overtook a waiting fetch, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt_o) begin
            starve_d = '0;
        end else if (ls_gnt_o && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory port mirrors the winner; idle cycles drive zeros.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ls_gnt_o) begin
            mem_req_o   = 1'b1;
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
        end else if (if_gnt_o) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = if_addr_i;
        end
    end

    // Stores occupy a pipe slot with valid = 0 so no response is produced.
    always_comb begin
        rd_issue_c = (ls_gnt_o & ~ls_we_i) | if_gnt_o;
        push_tag   = make_tag(rd_issue_c, ls_gnt_o ? OWN_LS : OWN_IF);
    end

    triumph_resp_pipe #(
        .DEPTH (RD_LAT)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .tag_i (push_tag),
        .tag_o (pipe_tag)
    );

    assign if_rvalid_o = pipe_tag.valid & (pipe_tag.owner == OWN_IF) & ~rst_i;
    assign ls_rvalid_o = pipe_tag.valid & (pipe_tag.owner == OWN_LS) & ~rst_i;
    assign if_rdata_o  = mem_rdata_i;
    assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_triumph_mem_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) share identical request
// streams; a spec-level model predicts grants and queued read responses.
module tb_triumph_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SMAX  = 4;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } ls_op_t;

    typedef struct {
        bit          own_ls;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          if_req   = 1'b0;
    logic [AW-1:0] if_addr  = '0;
    logic          ls_req   = 1'b0;
    logic          ls_we    = 1'b0;
    logic [AW-1:0] ls_addr  = '0;
    logic [DW-1:0] ls_wdata = '0;

    logic          a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_req, a_mem_we, a_stall;
    logic [DW-1:0] a_if_rdata, a_ls_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0] a_mem_addr;
    logic          b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_req, b_mem_we, b_stall;
    logic [DW-1:0] b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0] b_mem_addr;

    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    int     streak   = 0;
    int     n_ls_gnt = 0;
    bit     m_if_gnt = 0;
    bit     m_ls_gnt = 0;
    bit     e_if, e_ls, e_stall;

    logic [31:0] if_q[$];
    ls_op_t      ls_q[$];
    resp_t       qa[$];
    resp_t       qb[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] env_a   [logic [31:0]];
    logic [31:0] env_b   [logic [31:0]];
    logic [31:0] rd_a [LAT_A];
    logic [31:0] rd_b [LAT_B];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    triumph_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .STARVE_MAX(SMAX)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(a_if_gnt),
        .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_gnt_o(a_ls_gnt), .ls_rvalid_o(a_ls_rvalid), .ls_rdata_o(a_ls_rdata),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata), .stall_o(a_stall));

    triumph_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .STARVE_MAX(SMAX)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt),
        .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .stall_o(b_stall));

    function automatic logic [31:0] init_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Write-first memory macros with fixed read latency; idle cycles return junk.
    assign a_mem_rdata = rd_a[LAT_A-1];
    assign b_mem_rdata = rd_b[LAT_B-1];

    always @(posedge clk) begin
        if (a_mem_req && a_mem_we) env_a[a_mem_addr] = a_mem_wdata;
        if (b_mem_req && b_mem_we) env_b[b_mem_addr] = b_mem_wdata;
        rd_a[0] <= (a_mem_req && !a_mem_we) ?
                   (env_a.exists(a_mem_addr) ? env_a[a_mem_addr] : init_word(a_mem_addr)) : $urandom;
        rd_b[0] <= (b_mem_req && !b_mem_we) ?
                   (env_b.exists(b_mem_addr) ? env_b[b_mem_addr] : init_word(b_mem_addr)) : $urandom;
        for (int i = 1; i < int'(LAT_A); i++) rd_a[i] <= rd_a[i-1];
        for (int i = 1; i < int'(LAT_B); i++) rd_b[i] <= rd_b[i-1];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    task automatic check_arb(input string t, input logic ig, input logic lg, input logic st,
                             input logic mr, input logic mw, input logic [31:0] ma,
                             input logic [31:0] md);
        chk({t, ".if_gnt"}, 32'(ig), 32'(e_if));
        chk({t, ".ls_gnt"}, 32'(lg), 32'(e_ls));
        chk({t, ".stall"}, 32'(st), 32'(e_stall));
        chk({t, ".mem_req"}, 32'(mr), 32'(e_if | e_ls));
        chk({t, ".mem_we"}, 32'(mw), 32'(e_ls & ls_we));
        if (e_ls) chk({t, ".mem_addr"}, ma, ls_addr);
        else if (e_if) chk({t, ".mem_addr"}, ma, if_addr);
        if (e_ls && ls_we) chk({t, ".mem_wdata"}, md, ls_wdata);
        if (rst) begin
            chk({t, ".rst_mem_addr"}, ma, 32'h0);
            chk({t, ".rst_mem_wdata"}, md, 32'h0);
        end
    endtask

    // Reference model: one decision per cycle from the live requests and streak length.
    always @(negedge clk) begin
        resp_t r;
        e_if = 0;
        e_ls = 0;
        if (rst) begin
            streak = 0;
            qa.delete();
            qb.delete();
        end else if (ls_req && !(if_req && streak >= int'(SMAX))) begin
            e_ls = 1;
        end else if (if_req) begin
            e_if = 1;
        end
        e_stall = (if_req && !e_if) || (ls_req && !e_ls);
        check_arb("A", a_if_gnt, a_ls_gnt, a_stall, a_mem_req, a_mem_we, a_mem_addr, a_mem_wdata);
        check_arb("B", b_if_gnt, b_ls_gnt, b_stall, b_mem_req, b_mem_we, b_mem_addr, b_mem_wdata);
        if (e_ls && ls_we) begin
            ref_mem[ls_addr] = ls_wdata;
        end else if (e_ls || e_if) begin
            r.own_ls = e_ls;
            r.data   = e_ls ? (ref_mem.exists(ls_addr) ? ref_mem[ls_addr] : init_word(ls_addr))
                            : (ref_mem.exists(if_addr) ? ref_mem[if_addr] : init_word(if_addr));
            r.due = cyc + int'(LAT_A);
            qa.push_back(r);
            r.due = cyc + int'(LAT_B);
            qb.push_back(r);
        end
        if (!if_req || e_if) streak = 0;
        else if (e_ls && streak < int'(SMAX)) streak++;
        if (e_ls) n_ls_gnt++;
        m_if_gnt = e_if;
        m_ls_gnt = e_ls;
    end

    task automatic check_resp(input string t, input logic vi, input logic vl,
                              input logic [31:0] di, input logic [31:0] dl, ref resp_t q[$]);
        resp_t e;
        chk({t, ".both_rvalid"}, 32'(vi & vl), 32'h0);
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk({t, ".if_rvalid"}, 32'(vi), 32'(!e.own_ls));
            chk({t, ".ls_rvalid"}, 32'(vl), 32'(e.own_ls));
            chk({t, ".rdata"}, e.own_ls ? dl : di, e.data);
        end else begin
            chk({t, ".if_rvalid_idle"}, 32'(vi), 32'h0);
            chk({t, ".ls_rvalid_idle"}, 32'(vl), 32'h0);
        end
    endtask

    // Monitor: pops expected responses independently of the stimulus side.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check_resp("A", a_if_rvalid, a_ls_rvalid, a_if_rdata, a_ls_rdata, qa);
            check_resp("B", b_if_rvalid, b_ls_rvalid, b_if_rdata, b_ls_rdata, qb);
        end
    end

    // Driver: holds each request with stable fields until the model says it was granted.
    initial begin
        ls_op_t op;
        forever begin
            @(posedge clk);
            #1;
            if (if_req && m_if_gnt) if_req = 0;
            if (ls_req && m_ls_gnt) ls_req = 0;
            if (!if_req && if_q.size() > 0) begin
                if_addr = if_q.pop_front();
                if_req  = 1;
            end
            if (!ls_req && ls_q.size() > 0) begin
                op       = ls_q.pop_front();
                ls_we    = op.we;
                ls_addr  = op.addr;
                ls_wdata = op.wdata;
                ls_req   = 1;
            end
        end
    end

    function automatic ls_op_t mk_ls(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        ls_op_t o;
        o.we = we;
        o.addr = addr;
        o.wdata = wd;
        return o;
    endfunction

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            #2;
            done = (if_q.size() == 0) && (ls_q.size() == 0) && (!if_req || m_if_gnt) &&
                   (!ls_req || m_ls_gnt) && (qa.size() == 0) && (qb.size() == 0);
        end
        n_checks++;
        if (!done) begin
            n_err++;
            $display("FAIL timeout_%s cyc=%0d got=busy exp=idle", nm, cyc);
        end
    endtask

    initial begin
        int base;
        bit hit;
        // Fetch request pending through reset, then three back-to-back fetches.
        if_q.push_back(32'h0);
        if_q.push_back(32'h4);
        if_q.push_back(32'h8);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        wait_idle("fetch");

        // Both ports saturated: expect LS x4 then IF, repeating.
        for (int i = 0; i < 3; i++) if_q.push_back(32'h40 + 32'(i * 4));
        for (int i = 0; i < 12; i++) ls_q.push_back(mk_ls(0, 32'h80 + 32'(i * 4), 32'h0));
        wait_idle("starve");

        // Store then immediately load the same word.
        ls_q.push_back(mk_ls(1, 32'h100, 32'hDEAD_BEEF));
        ls_q.push_back(mk_ls(0, 32'h100, 32'h0));
        wait_idle("st_ld");

        // Alternating single-port reads.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (i % 2 == 0) if_q.push_back(32'h200 + 32'(i * 4));
            else ls_q.push_back(mk_ls(0, 32'h200 + 32'(i * 4), 32'h0));
        end
        wait_idle("interleave");

        // Saturate the counter with reads in flight, then reset for one cycle.
        base = n_ls_gnt;
        if_q.push_back(32'h300);
        for (int i = 0; i < 4; i++) ls_q.push_back(mk_ls(0, 32'h310 + 32'(i * 4), 32'h0));
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            #2;
            hit = (n_ls_gnt >= base + 4);
        end
        n_checks++;
        if (!hit) begin
            n_err++;
            $display("FAIL timeout_rst_setup cyc=%0d got=%0d exp=%0d", cyc, n_ls_gnt - base, 4);
        end
        @(posedge clk);
        ls_q.push_back(mk_ls(0, 32'h304, 32'h0));
        #1 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        wait_idle("rst_mid");

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            if (if_q.size() < 2 && $urandom_range(0, 2) != 0)
                if_q.push_back({26'h0, 4'($urandom_range(0, 15)), 2'b00});
            if (ls_q.size() < 2 && $urandom_range(0, 2) != 0)
                ls_q.push_back(mk_ls(1'($urandom_range(0, 1)),
                                     {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom));
            #1 rst = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk);
        #1 rst = 0;
        wait_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
